bus_rr_arbiter: RTL
===================

Name: bus_rr_arbiter

Overview:
Round-robin arbiter for the shared serial bus (b_BUS / b_RW / b_bus_utilizing) used by up to 12 masters and 6 slaves. It is an alternative to the fixed-priority bus controller. It issues one-hot grants and tracks bus utilisation through the master's handshake. It recovers from masters that are granted but never drive b_bus_utilizing, and it defers new grants while any slave holds the bus for a response.

Parameters:
NUM_MASTERS, 12, number of request/grant pairs
NUM_SLAVES, 6, width of the slave-busy vector
ID_WIDTH, 4, width of mid_current; must satisfy 2^ID_WIDTH >= NUM_MASTERS
TIMEOUT_LEN, 6, width in bits of the grant-acceptance watchdog; timeout fires at 2^TIMEOUT_LEN cycles

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
m_reqs  input  NUM_MASTERS  per-master bus request, held for the whole transaction
m_grants  output  NUM_MASTERS  one-hot grant, registered
slaves  input  NUM_SLAVES  per-slave busy/response-pending flags
bus_util  input  1  b_bus_utilizing, driven high by the master that owns the bus
state  output  3  current FSM state, for debug
mid_current  output  ID_WIDTH  index of the last granted master
timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset state, taken on the rising clk edge with rst=1: state=IDLE, m_grants=0, mid_current=0, timeout=0, last-served pointer=NUM_MASTERS-1 (so master 0 wins first), watchdog=0. rst has priority over every other condition and aborts any state on that edge.
- Selection is round-robin. The search starts at (last+1) mod NUM_MASTERS and increments with wrap-around. The first asserted m_reqs bit wins.
- IDLE (0): m_grants=0.
  - Move to GRANT only if |m_reqs=1, bus_util=0 and |slaves=0.
  - On that edge: m_grants gets the one-hot winner, mid_current and last get the winner index, watchdog clears.
  - Latency: a request sampled at edge n produces its grant visible after edge n.
- GRANT (1): grant held and watchdog increments.
  - If bus_util=1 and the granted req=1: go to ACTIVE.
  - If the granted req drops, including on the same cycle that bus_util rises: go to RELEASE.
  - If the watchdog reaches 2^TIMEOUT_LEN-1 without bus_util: go to RELEASE, pulse timeout for 1 cycle, clear m_grants.
- ACTIVE (2): grant held while the granted req=1, regardless of bus_util. bus_util may drop while the master waits on a slave. When the granted req=0: clear m_grants and go to RELEASE.
- RELEASE (3): m_grants=0.
  - Stay until bus_util=0, then go to IDLE.
  - This guarantees at least one idle cycle between owners.
  - The earliest regrant is 2 edges after the req drop.
- Requests from non-granted masters never affect the current grant; there is no preemption.
- m_grants is always 0 or one-hot, never multi-hot.
- Encodings 4-7 are illegal and return to IDLE with grants cleared.
- Request bits at index >= NUM_MASTERS do not exist; mid_current never exceeds NUM_MASTERS-1.

Decomposition:
- Shared include bus_arb_defs.vh holds the state encodings (IDLE=0, GRANT=1, ACTIVE=2, RELEASE=3) and the default NUM_MASTERS/NUM_SLAVES/ID_WIDTH values. The existing bus controller and testbenches use the same file.
- One sub-module, bus_rr_pick, is natural. It is purely combinational:
  - inputs: reqs[NUM_MASTERS], last[ID_WIDTH]
  - outputs: valid, idx[ID_WIDTH], onehot[NUM_MASTERS]
- bus_rr_arbiter registers bus_rr_pick's outputs.

Test Plan:
- Reset then m_reqs=12'h020 -> m_grants=12'h020 one edge later and mid_current=5. Raise bus_util: state=ACTIVE. Drop req: m_grants=0 next edge, state=RELEASE. Drop bus_util: IDLE.
- m_reqs=12'h821 held with each owner cycling bus_util -> grant order 0,5,11,0,5. mid_current follows that order, with never more than one grant bit high.
- Grant master 3 with bus_util never raised -> timeout pulse 64 cycles after the grant (TIMEOUT_LEN=6), m_grants=0. Next grant goes to the next requester after master 3.
- slaves=6'b001000 with m_reqs=12'h001 -> no grant while busy. Clear slaves -> m_grants=12'h001 one edge later.
- In GRANT for master 2, drop req on the same cycle bus_util rises -> RELEASE, not ACTIVE. Grant stays 0 until bus_util falls.
- Assert rst for 1 cycle during ACTIVE for master 7 -> m_grants=0, mid_current=0, state=IDLE after that edge. The next request from masters 7 and 0 grants master 0.

Source files
------------

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: default sizes and FSM states.
package bus_rr_arbiter_pkg;

   localparam int unsigned DEF_NUM_MASTERS = 12;
   localparam int unsigned DEF_NUM_SLAVES  = 6;
   localparam int unsigned DEF_ID_WIDTH    = 4;
   localparam int unsigned DEF_TIMEOUT_LEN = 6;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT   = 3'd1,
      ACTIVE  = 3'd2,
      RELEASE = 3'd3
   } arb_state_t;

endpackage

// File: rtl/bus_rr_arbiter_pick.sv
// Combinational round-robin picker: first asserted request after 'last', with wrap-around.
module bus_rr_pick
   import bus_rr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH
) (
   input  logic [NUM_MASTERS-1:0] reqs,
   input  logic [ID_WIDTH-1:0]    last,
   output logic                   valid,
   output logic [ID_WIDTH-1:0]    idx,
   output logic [NUM_MASTERS-1:0] onehot
);

   int unsigned j;

   // Scan from last+1 upward, wrapping; the first set request wins.
   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      onehot = '0;
      j      = 0;
      for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
         j = (32'(last) + k) % NUM_MASTERS;
         if (!valid && reqs[j]) begin
            valid     = 1'b1;
            idx       = ID_WIDTH'(j);
            onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared serial bus with grant-acceptance watchdog.
module bus_rr_arbiter
   import bus_rr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES,
   parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH,
   parameter int unsigned TIMEOUT_LEN = DEF_TIMEOUT_LEN
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] m_reqs,
   output logic [NUM_MASTERS-1:0] m_grants,
   input  logic [NUM_SLAVES-1:0]  slaves,
   input  logic                   bus_util,
   output logic [2:0]             state,
   output logic [ID_WIDTH-1:0]    mid_current,
   output logic                   timeout
);

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] grants_q, grants_d;
   logic [ID_WIDTH-1:0]    mid_q, mid_d;
   logic [ID_WIDTH-1:0]    last_q, last_d;
   logic [TIMEOUT_LEN-1:0] wd_q, wd_d;
   logic                   timeout_q, timeout_d;

   logic                   pick_valid;
   logic [ID_WIDTH-1:0]    pick_idx;
   logic [NUM_MASTERS-1:0] pick_onehot;
   logic                   owner_req;

   bus_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .ID_WIDTH    (ID_WIDTH)
   ) u_pick (
      .reqs   (m_reqs),
      .last   (last_q),
      .valid  (pick_valid),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   // Only the current owner's request matters while a grant is held.
   assign owner_req = |(m_reqs & grants_q);

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      grants_d  = grants_q;
      mid_d     = mid_q;
      last_d    = last_q;
      wd_d      = wd_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            grants_d = '0;
            if (pick_valid && !bus_util && !(|slaves)) begin
               state_d  = GRANT;
               grants_d = pick_onehot;
               mid_d    = pick_idx;
               last_d   = pick_idx;
               wd_d     = '0;
            end
         end
         GRANT: begin
            // A dropped request beats a simultaneous bus_util rise.
            if (!owner_req) begin
               state_d  = RELEASE;
               grants_d = '0;
            end else if (bus_util) begin
               state_d = ACTIVE;
            end else if (wd_q == '1) begin
               state_d   = RELEASE;
               grants_d  = '0;
               timeout_d = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ACTIVE: begin
            if (!owner_req) begin
               state_d  = RELEASE;
               grants_d = '0;
            end
         end
         RELEASE: begin
            grants_d = '0;
            if (!bus_util) state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            grants_d = '0;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         grants_q  <= '0;
         mid_q     <= '0;
         last_q    <= ID_WIDTH'(NUM_MASTERS - 1);
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grants_q  <= grants_d;
         mid_q     <= mid_d;
         last_q    <= last_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign m_grants    = grants_q;
   assign state       = state_q;
   assign mid_current = mid_q;
   assign timeout     = timeout_q;

endmodule
